// File: rtl/dm_mover_pkg.sv
// Shared encodings and default widths for the data-memory block mover.
// Optional checksum output is controlled by DM_MOVER_CSUM_EN.
package dm_mover_pkg;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    // Base plus word index, wrapping modulo 2^AW.
    function automatic logic [AW-1:0] addr_off(input logic [AW-1:0] base,
                                               input logic [LW-1:0] idx);
        return base + AW'(idx);
    endfunction

endpackage

// File: rtl/dm_mover_if.sv
// Request/status and data-memory port bundle of dm_mover.
// The csum signal exists only when DM_MOVER_CSUM_EN is defined.
interface dm_mover_if;
    import dm_mover_pkg::*;

    logic          start;
    logic          op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [DW-1:0] fill_val;
    logic          busy;
    logic          done;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic          dm_we;
    logic [DW-1:0] dm_dout;
`ifdef DM_MOVER_CSUM_EN
    logic [DW-1:0] csum;

    modport master (
        input  start, op, src, dst, len, fill_val, dm_dout,
        output busy, done, dm_addr, dm_din, dm_we, csum
    );
    modport slave (
        output start, op, src, dst, len, fill_val, dm_dout,
        input  busy, done, dm_addr, dm_din, dm_we, csum
    );
`else
    modport master (
        input  start, op, src, dst, len, fill_val, dm_dout,
        output busy, done, dm_addr, dm_din, dm_we
    );
    modport slave (
        output start, op, src, dst, len, fill_val, dm_dout,
        input  busy, done, dm_addr, dm_din, dm_we
    );
`endif

endinterface

// File: rtl/dm_mover.sv
// Purpose: copies len words src->dst (2 cycles/word) or fills len words at dst (1 cycle/word); optional DM_MOVER_CSUM_EN checksum.
// Latency: busy from the start edge, done pulses one cycle after the last write (cycle after start when len=0).
// Backpressure: none; start is taken only in IDLE and dropped otherwise, memory is assumed single-cycle.
module dm_mover
    import dm_mover_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    dm_mover_if.master bus
);

    logic [1:0]    state_q, state_d;
    logic          op_q, op_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic [LW-1:0] idx_inc;
    logic [DW-1:0] wr_dat;
`ifdef DM_MOVER_CSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    assign idx_inc = idx_q + LW'(1);
    assign wr_dat  = (op_q == OP_FILL) ? fill_q : data_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        data_d  = data_q;
`ifdef DM_MOVER_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    src_d  = bus.src;
                    dst_d  = bus.dst;
                    len_d  = bus.len;
                    fill_d = bus.fill_val;
                    idx_d  = '0;
`ifdef DM_MOVER_CSUM_EN
                    csum_d = '0;
`endif
                    if (bus.len == '0)
                        state_d = ST_DONE;
                    else if (bus.op == OP_FILL)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                data_d  = bus.dm_dout;
                state_d = ST_WR;
            end
            ST_WR: begin
                idx_d = idx_inc;
`ifdef DM_MOVER_CSUM_EN
                csum_d = csum_q + wr_dat;
`endif
                if (idx_inc == len_q)
                    state_d = ST_DONE;
                else if (op_q == OP_FILL)
                    state_d = ST_WR;
                else
                    state_d = ST_RD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
`ifdef DM_MOVER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
`ifdef DM_MOVER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Outputs decode from registered state only, so reset drops dm_we at once.
    always_comb begin
        bus.busy    = (state_q == ST_RD) || (state_q == ST_WR);
        bus.done    = (state_q == ST_DONE);
        bus.dm_we   = (state_q == ST_WR);
        bus.dm_din  = (state_q == ST_WR) ? wr_dat : '0;
        bus.dm_addr = '0;
        if (state_q == ST_RD)
            bus.dm_addr = addr_off(src_q, idx_q);
        else if (state_q == ST_WR)
            bus.dm_addr = addr_off(dst_q, idx_q);
    end

`ifdef DM_MOVER_CSUM_EN
    assign bus.csum = csum_q;
`endif

endmodule

// File: doc/dm_mover.md
# dm_mover

Block-transfer initiator for the data memory port: on a single start strobe it copies `len` consecutive words from `src` to `dst`, or fills `len` words at `dst` with a constant. It drives the memory's `addr`/`din`/`we` inputs and consumes its combinational read data. It sits beside the core as a second data-memory master, muxed onto the DM port by the owner of `busy`.

## Interface
- `AW`, 8: memory address width.
- `DW`, 16: memory data width.
- `LW`, 8: transfer length width (maximum 2^LW−1 words).

- `clk`, in, 1: single clock; all state changes on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request strobe; accepted only in IDLE.
- `op`, in, 1: 0 = COPY, 1 = FILL.
- `src`, in, AW: first source address (COPY only).
- `dst`, in, AW: first destination address.
- `len`, in, LW: word count.
- `fill_val`, in, DW: FILL data.
- `busy`, out, 1: transfer in progress (RD/WR states).
- `done`, out, 1: one-cycle completion pulse.
- `dm_addr`, out, AW: memory address.
- `dm_din`, out, DW: memory write data.
- `dm_we`, out, 1: memory write enable.
- `dm_dout`, in, DW: memory read data, combinational from `dm_addr`.

## Operation
- States are IDLE, RD, WR, and DONE.
- IDLE with `start`=1 at an edge:
  - Latch `op`, `src`, `dst`, `len`, `fill_val`.
  - Clear the index.
  - If `len`=0, go to DONE.
  - Otherwise go to RD for COPY, or WR for FILL.
- RD: `dm_addr`=src_q+idx, `dm_we`=0. At the edge, capture `dm_dout` into data_q and go to WR.
- WR: `dm_addr`=dst_q+idx, `dm_din`=data_q (COPY) or fill_q (FILL), `dm_we`=1. At the edge, idx+1:
  - If idx+1 equals len_q, go to DONE.
  - Otherwise go to RD (COPY) or stay in WR (FILL).
- DONE: `done`=1, `busy`=0; go to IDLE at the next edge.
- Address arithmetic is modulo 2^AW, so addresses wrap silently from 0xFF to 0x00.
- The copy order is strictly ascending. Overlapping regions behave exactly as this word-at-a-time order dictates (dst>src overlap propagates source words); no special handling.
- `start` in RD, WR, or DONE is ignored, with no queueing.
- In IDLE, RD, and DONE: `dm_we`=0, `dm_din`=0.
- In IDLE and DONE: `dm_addr`=0.

## Timing
- Reset (async, immediate):
  - State IDLE.
  - `busy`=0, `done`=0, `dm_we`=0, `dm_addr`=0, `dm_din`=0.
  - All latched registers cleared.
- Reset asserted mid-transfer drops `dm_we` without waiting for a clock. Words already written stay; the rest are not written. No resume.
- Start accepted at edge E0; `busy`=1 from E0.
- COPY of N words:
  - Busy for 2N cycles.
  - Word k is read in cycle 2k+1 and written at the end of cycle 2k+2.
  - `done` is high in cycle 2N+1.
- FILL of N words: busy for N cycles; `done` is high in cycle N+1.
- `len`=0: `done` is high in the cycle after E0; `busy` never rises; no memory access.
- The earliest next start is accepted in the cycle after `done` (back in IDLE).
- Outputs decode from registered state/counters only, with no combinational path from `start` or `dm_dout` to any output.

## Configuration
- Macro: `DM_MOVER_CSUM_EN`.
- When defined:
  - Adds output `csum` [DW-1:0]: a wrapping modulo-2^DW sum of every word written during the last transfer.
  - `csum` clears on start acceptance and is stable from `done` until the next start.
  - Reset value 0.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

## Structure
- Shared package `dm_mover_pkg` holds:
  - The state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3).
  - The op encoding (OP_COPY=1'b0, OP_FILL=1'b1).
  - Default widths AW/DW/LW.
- No sub-module: the FSM, index counter, adders and optional checksum accumulator are one module.

## Test plan
- Memory model preloaded: [0]=0x0127, [1]=0x0541, [2]=0x0059. COPY src=0 dst=0x20 len=3.
  - Required: [0x20..0x22] become 0x0127/0x0541/0x0059.
  - `busy` lasts 6 cycles; `done` is in cycle 7.
  - With CSUM_EN, `csum`=0x06C1.
- FILL dst=0x40 len=4 fill_val=0xBEEF.
  - Required: [0x40..0x43]=0xBEEF; `dm_we` is high 4 consecutive cycles.
  - `done` is in cycle 5.
- `len`=0 with COPY.
  - Required: `dm_we` never asserts; `done` in cycle 1; `busy` stays 0.
- Wrap: FILL dst=0xFE len=3 fill_val=0x1111.
  - Required: writes to 0xFE, 0xFF, 0x00 in that order; 0x01 untouched.
- Preload [3..5]=0x00aa/0x0102/0x0048, then COPY src=3 dst=4 len=2.
  - Required: [4]=0x00aa, [5]=0x00aa (ascending overlap).
  - A second `start` pulsed mid-transfer is ignored.
- Start COPY len=5, deassert `reset_n` after the 2nd write cycle.
  - Required: `dm_we`/`busy` drop immediately; only 2 words written.
  - After release, IDLE; a fresh start proceeds normally.
